keypad_entry: RTL and testbench
===============================

# keypad_entry

Front-end for the number-guessing game. Takes the raw 12-key keypad vector, synchronises and debounces it, and decodes single presses. It builds a two-digit decimal entry and emits a one-cycle enter strobe with the captured value. It sits directly upstream of the game controller, replacing the separate scan/display/register/decimal-conversion path with one registered source of digits, value and enter.

## Interface
- DB_CYCLES, 100000: number of consecutive stable clock cycles required before the debounced key vector updates (minimum 2).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- keypad_in  input  12  raw key levels, 1 = pressed. Mapping: bit0..8 = keys '1'..'9', bit9 = '*', bit10 = '0', bit11 = '#'.
- dig_tens  output  4  BCD tens digit of the live entry.
- dig_ones  output  4  BCD ones digit of the live entry.
- dig_count  output  2  number of digits entered (0..2).
- value  output  7  live binary value, dig_tens*10 + dig_ones (0..99). Combinational from the digit registers.
- enter  output  1  one-cycle strobe on an accepted '*' press.
- entry  output  7  binary value captured at the last enter; held until the next enter.

## Operation
- Synchroniser: 2-flop synchroniser on all 12 bits, giving sync_keys.
- Debouncer:
  - Counter clears whenever sync_keys differs from its previous-cycle sample.
  - Otherwise the counter increments, saturating.
  - When the counter reaches DB_CYCLES-1 with the value unchanged, db_keys <= sync_keys.
- Press FSM, two states:
  - S_IDLE: if db_keys has exactly one bit set, perform the key action and go to S_HELD.
  - S_IDLE: if db_keys has two or more bits set, go to S_HELD with no action (chord lockout).
  - S_HELD: stay until db_keys == 0, then return to S_IDLE.
  - There is no auto-repeat. One action per press-release.
- Key actions:
  - Digit d when dig_count < 2: dig_tens <= dig_ones, dig_ones <= d, dig_count++.
  - Digit d when dig_count == 2: same shift (rolling, keeps the last two digits); dig_count stays 2.
  - '#': dig_tens, dig_ones and dig_count <= 0. enter and entry are unaffected.
  - '*' when dig_count > 0:
    - enter <= 1 for one cycle and entry <= value.
    - Digits and dig_count clear on the same edge, so entry holds the pre-clear value.
  - '*' when dig_count == 0: ignored. No strobe; entry unchanged.
- Arithmetic: value = {dig_tens,3'b0} + {dig_tens,1'b0} + dig_ones, truncated to 7 bits. The maximum is 99, so there is no overflow.

## Timing
- Reset (rst low, asynchronous): all outputs 0. db_keys = 0, counter = 0, synchroniser flops 0, FSM = S_IDLE.
- Latency: keypad_in changes and stays stable, first sampled at edge 0. The action (digit registers update / enter high) is visible after edge DB_CYCLES+3:
  - 2 edges through the synchroniser,
  - DB_CYCLES edges to update db_keys,
  - 1 edge for the FSM action.
- Release has the same DB_CYCLES+2 latency to db_keys == 0. The FSM returns to S_IDLE on the following edge.
- Bounce: any toggle shorter than DB_CYCLES synced cycles never reaches db_keys.
- enter is high for exactly one cycle per accepted '*'. Its earliest re-assertion requires a full release plus a new press.
- Simultaneous keys: two keys debounced together cause a lockout. A second key pressed while the first is held is ignored; no action occurs until all keys are released.
- Key held through reset: treated as a fresh press once debounced after reset deasserts.
- Reset mid-press or mid-debounce: all state clears immediately; no partial action completes.

## Test plan
All scenarios use DB_CYCLES = 4.
- Press '4' (bit3) for 20 cycles, then release. dig_ones = 4, dig_count = 1, value = 4, after exactly 7 edges. No further change on release.
- Press '5' (bit4), then '7' (bit6), then '*' (bit9), each with a clean release:
  - enter pulses for 1 cycle with entry = 57.
  - dig_count = 0 and value = 0 on the same edge.
  - entry stays 57 afterwards.
- Press '1', then '2', then '3'. Result: dig_tens = 2, dig_ones = 3, dig_count = 2, value = 23. Then '#' gives all digit outputs 0, with entry unchanged.
- Bounce '8': toggle bit7 every 2 cycles for 16 cycles, then hold 10 cycles. Exactly one action results: dig_ones = 8, dig_count = 1.
- Chord '1'+'2' asserted together, then released → no change. With '3' held, assert '9' as well, then release both → only the '3' action occurs.
- '*' with dig_count = 0 produces no enter pulse. Pulling rst low mid-debounce while '6' is held clears all outputs asynchronously. Keeping '6' held after rst deasserts gives dig_ones = 6 after 7 edges.

Source files
------------

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_entry
// Purpose  : Keypad front-end for the number-guessing game. Synchronises and
//            debounces the raw 12-key vector, decodes single presses and
//            builds a two-digit decimal entry with a one-cycle enter strobe.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous reset, active low
//            keypad_in  - raw key levels, 1 = pressed
//                         bit0..8 = '1'..'9', bit9 = '*', bit10 = '0', bit11 = '#'
//            dig_tens   - BCD tens digit of the live entry
//            dig_ones   - BCD ones digit of the live entry
//            dig_count  - digits entered (0..2)
//            value      - live binary value, dig_tens*10 + dig_ones
//            enter      - one-cycle strobe on an accepted '*'
//            entry      - value captured at the last enter
// Revision : 1.0 - initial release
// ============================================================================
module keypad_entry #(
  parameter int DB_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keypad_in,
  output logic [3:0]  dig_tens,
  output logic [3:0]  dig_ones,
  output logic [1:0]  dig_count,
  output logic [6:0]  value,
  output logic        enter,
  output logic [6:0]  entry
);

  localparam int            CW        = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Synchroniser and debouncer
  // --------------------------------------------------------------------------
  logic [11:0]   r_sync1;
  logic [11:0]   r_sync2;
  logic [11:0]   r_prev;
  logic [11:0]   r_db;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_stable;

  // The counter tracks how many consecutive cycles the synced vector has
  // matched its previous sample; db_keys loads on the cycle the count
  // reaches DB_CYCLES-1 and keeps reloading the same value while saturated.
  always_comb begin
    w_stable   = (r_sync2 == r_prev);
    w_cnt_next = r_cnt;
    if (!w_stable) begin
      w_cnt_next = '0;
    end else if (r_cnt != C_CNT_MAX) begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
      r_db    <= '0;
    end else begin
      r_sync1 <= keypad_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_cnt   <= w_cnt_next;
      if (w_stable && (w_cnt_next == C_CNT_MAX)) begin
        r_db <= r_sync2;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Key decode
  // --------------------------------------------------------------------------
  logic       w_one_hot;
  logic [3:0] w_idx;
  logic       w_is_digit;
  logic [3:0] w_digit;

  always_comb begin
    // x & (x-1) clears the lowest set bit, so zero means at most one key.
    w_one_hot = (r_db != 12'd0) && ((r_db & (r_db - 12'd1)) == 12'd0);
    w_idx     = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (r_db[i]) begin
        w_idx = 4'(i);
      end
    end
    w_is_digit = (w_idx <= 4'd8) || (w_idx == 4'd10);
    w_digit    = (w_idx == 4'd10) ? 4'd0 : (w_idx + 4'd1);
  end

  // --------------------------------------------------------------------------
  // Press FSM and entry registers
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] w_tens_next;
  logic [3:0] w_ones_next;
  logic [1:0] w_count_next;
  logic       w_enter_next;
  logic [6:0] w_entry_next;

  assign value = {dig_tens, 3'b000} + {2'b00, dig_tens, 1'b0} + {3'b000, dig_ones};

  always_comb begin
    w_state_next = r_state;
    w_tens_next  = dig_tens;
    w_ones_next  = dig_ones;
    w_count_next = dig_count;
    w_enter_next = 1'b0;
    w_entry_next = entry;
    case (r_state)
      S_IDLE: begin
        if (w_one_hot) begin
          w_state_next = S_HELD;
          if (w_is_digit) begin
            // Rolling shift keeps the two most recent digits.
            w_tens_next = dig_ones;
            w_ones_next = w_digit;
            if (dig_count != 2'd2) begin
              w_count_next = dig_count + 2'd1;
            end
          end else if (w_idx == 4'd11) begin
            w_tens_next  = 4'd0;
            w_ones_next  = 4'd0;
            w_count_next = 2'd0;
          end else if (dig_count != 2'd0) begin
            // '*': capture the pre-clear value on the same edge as the clear.
            w_enter_next = 1'b1;
            w_entry_next = value;
            w_tens_next  = 4'd0;
            w_ones_next  = 4'd0;
            w_count_next = 2'd0;
          end
        end else if (r_db != 12'd0) begin
          // Chord: lock out until every key is released.
          w_state_next = S_HELD;
        end
      end
      S_HELD: begin
        if (r_db == 12'd0) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      dig_tens  <= 4'd0;
      dig_ones  <= 4'd0;
      dig_count <= 2'd0;
      enter     <= 1'b0;
      entry     <= 7'd0;
    end else begin
      r_state   <= w_state_next;
      dig_tens  <= w_tens_next;
      dig_ones  <= w_ones_next;
      dig_count <= w_count_next;
      enter     <= w_enter_next;
      entry     <= w_entry_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_entry
// Purpose  : Self-checking bench for keypad_entry (DB_CYCLES = 4). Directed
//            scenarios followed by random key activity, all compared every
//            cycle against a behavioural model of the keypad front-end.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

  logic        clk;
  logic        rst;
  logic [11:0] keypad_in;
  logic [3:0]  dig_tens;
  logic [3:0]  dig_ones;
  logic [1:0]  dig_count;
  logic [6:0]  value;
  logic        enter;
  logic [6:0]  entry;

  keypad_entry #(.DB_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .keypad_in (keypad_in),
    .dig_tens  (dig_tens),
    .dig_ones  (dig_ones),
    .dig_count (dig_count),
    .value     (value),
    .enter     (enter),
    .entry     (entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_enter = 0;
  int cnt_at_enter = -1;

  // Behavioural model: raw-sample history, debounced vector, held flag and
  // the entry state as plain integers.
  logic [11:0] m_hist[6];
  logic [11:0] m_db;
  bit          m_held;
  int          m_tens, m_ones, m_cnt, m_entry;
  bit          m_enter;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_hist[i] = 12'd0;
    m_db = 12'd0; m_held = 0; m_enter = 0;
    m_tens = 0; m_ones = 0; m_cnt = 0; m_entry = 0;
  endtask

  task automatic model_edge(input logic [11:0] raw);
    int k;
    m_enter = 0;
    if (!m_held) begin
      if ($countones(m_db) == 1) begin
        m_held = 1;
        k = 0;
        for (int i = 0; i < 12; i++) if (m_db[i]) k = i;
        if (k <= 8 || k == 10) begin
          m_tens = m_ones;
          m_ones = (k == 10) ? 0 : k + 1;
          if (m_cnt < 2) m_cnt++;
        end else if (k == 11) begin
          m_tens = 0; m_ones = 0; m_cnt = 0;
        end else if (m_cnt > 0) begin
          m_enter = 1;
          m_entry = m_tens * 10 + m_ones;
          m_tens = 0; m_ones = 0; m_cnt = 0;
        end
      end else if ($countones(m_db) > 1) begin
        m_held = 1;
      end
    end else if (m_db == 12'd0) begin
      m_held = 0;
    end
    // A key vector reaches the debounced output once four consecutive
    // raw samples agree, two synchroniser stages after the last of them.
    for (int i = 5; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = raw;
    if (m_hist[2] == m_hist[3] && m_hist[3] == m_hist[4] && m_hist[4] == m_hist[5])
      m_db = m_hist[5];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_model();
    chk("dig_tens", 32'(dig_tens), 32'(m_tens));
    chk("dig_ones", 32'(dig_ones), 32'(m_ones));
    chk("dig_count", 32'(dig_count), 32'(m_cnt));
    chk("value", 32'(value), 32'(m_tens * 10 + m_ones));
    chk("enter", 32'(enter), 32'(m_enter));
    chk("entry", 32'(entry), 32'(m_entry));
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic [11:0] keys);
    keypad_in = keys;
    @(posedge clk);
    model_edge(keys);
    #1;
    if (enter === 1'b1) begin
      n_enter++;
      cnt_at_enter = int'(dig_count);
    end
    chk_model();
    @(negedge clk);
  endtask

  task automatic press(input logic [11:0] keys, input int hold, input int rel);
    repeat (hold) step(keys);
    repeat (rel) step(12'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tens"}, 32'(dig_tens), 32'd0);
    chk({tag, "_ones"}, 32'(dig_ones), 32'd0);
    chk({tag, "_count"}, 32'(dig_count), 32'd0);
    chk({tag, "_value"}, 32'(value), 32'd0);
    chk({tag, "_enter"}, 32'(enter), 32'd0);
    chk({tag, "_entry"}, 32'(entry), 32'd0);
  endtask

  initial begin
    logic [11:0] mask;
    int          r;
    rst = 1'b0;
    keypad_in = 12'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // '4' pressed: action lands on exactly the seventh edge.
    repeat (6) step(12'h008);
    chk("p4_before", 32'(dig_count), 32'd0);
    step(12'h008);
    chk("p4_ones", 32'(dig_ones), 32'd4);
    chk("p4_count", 32'(dig_count), 32'd1);
    chk("p4_value", 32'(value), 32'd4);
    press(12'h008, 13, 12);
    chk("p4_release", 32'(dig_count), 32'd1);

    // '5', '7', '*' -> enter with entry 57, digits cleared on the same edge.
    press(12'h800, 10, 10);
    n_enter = 0;
    press(12'h010, 10, 10);
    press(12'h040, 10, 10);
    press(12'h200, 10, 10);
    chk("e57_pulses", 32'(n_enter), 32'd1);
    chk("e57_cnt_at_enter", 32'(cnt_at_enter), 32'd0);
    chk("e57_entry", 32'(entry), 32'd57);
    chk("e57_value", 32'(value), 32'd0);

    // '1','2','3' roll to 23; '#' clears digits only.
    press(12'h001, 10, 10);
    press(12'h002, 10, 10);
    press(12'h004, 10, 10);
    chk("r23_tens", 32'(dig_tens), 32'd2);
    chk("r23_ones", 32'(dig_ones), 32'd3);
    chk("r23_count", 32'(dig_count), 32'd2);
    chk("r23_value", 32'(value), 32'd23);
    press(12'h800, 10, 10);
    chk("hash_count", 32'(dig_count), 32'd0);
    chk("hash_value", 32'(value), 32'd0);
    chk("hash_entry", 32'(entry), 32'd57);

    // Bouncing '8' yields a single action.
    for (int i = 0; i < 16; i++) step(((i / 2) % 2 == 0) ? 12'h080 : 12'h000);
    press(12'h080, 10, 10);
    chk("bounce_ones", 32'(dig_ones), 32'd8);
    chk("bounce_count", 32'(dig_count), 32'd1);

    // Chords are locked out; a second key during a hold is ignored.
    press(12'h800, 10, 10);
    press(12'h003, 10, 10);
    chk("chord_count", 32'(dig_count), 32'd0);
    repeat (10) step(12'h004);
    press(12'h104, 10, 10);
    chk("hold3_ones", 32'(dig_ones), 32'd3);
    chk("hold3_count", 32'(dig_count), 32'd1);

    // '*' with nothing entered is ignored.
    press(12'h800, 10, 10);
    n_enter = 0;
    press(12'h200, 10, 10);
    chk("star_empty_pulses", 32'(n_enter), 32'd0);
    chk("star_empty_entry", 32'(entry), 32'd57);

    // Reset mid-debounce of '6', then '6' held through reset.
    press(12'h100, 10, 10);
    repeat (4) step(12'h020);
    rst = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) step(12'h020);
    chk("post_rst_before", 32'(dig_count), 32'd0);
    step(12'h020);
    chk("post_rst_ones", 32'(dig_ones), 32'd6);
    chk("post_rst_count", 32'(dig_count), 32'd1);
    press(12'h020, 3, 10);

    // Random key activity: singles, chords, idle gaps and short glitches.
    repeat (220) begin
      r = $urandom_range(0, 9);
      if (r < 6) mask = 12'(1) << $urandom_range(0, 11);
      else if (r < 8) mask = 12'd0;
      else mask = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      repeat ($urandom_range(1, 14)) step(mask);
    end
    press(12'd0, 0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
